// File: rtl/pool_channel_sched.sv
// rtl/pool_channel_sched.sv - per-layer channel scheduler for the LeNet-5 pooling stage
// Optional watchdog on the POOL wait is built in when POOL_WDOG_EN is defined.
module pool_channel_sched #(
    parameter int NUM_CH   = 16,
    parameter int CH_W     = 4,
    parameter int GAP_CYC  = 2,
    parameter int WDOG_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            conv_done,
    input  logic            pool_done,
    output logic            conv_start,
    output logic            cal_en,
    output logic [CH_W-1:0] ch_sel,
    output logic            busy,
    output logic            layer_done,
    output logic            err
);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_POOL, S_GAP, S_DONE} state_t;

    localparam int              GW       = $clog2(GAP_CYC + 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYC);

    state_t          r_state, w_state;
    logic [GW-1:0]   r_gap, w_gap;
    logic [CH_W-1:0] r_ch_sel, w_ch_sel;
    logic            r_conv_start, w_conv_start;
    logic            r_cal_en, w_cal_en;
    logic            r_busy, w_busy;
    logic            r_layer_done, w_layer_done;
    logic            r_err, w_err;

`ifdef POOL_WDOG_EN
    localparam int            WW       = $clog2(WDOG_CYC + 1);
    localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_CYC);
    logic [WW-1:0] r_wdog, w_wdog;
`else
    // WDOG_CYC only takes effect when the watchdog is built in.
    if (WDOG_CYC < 1) begin : g_wdog_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gap        <= '0;
            r_ch_sel     <= '0;
            r_conv_start <= 1'b0;
            r_cal_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_gap        <= w_gap;
            r_ch_sel     <= w_ch_sel;
            r_conv_start <= w_conv_start;
            r_cal_en     <= w_cal_en;
            r_busy       <= w_busy;
            r_layer_done <= w_layer_done;
            r_err        <= w_err;
        end
    end

`ifdef POOL_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wdog <= '0;
        else        r_wdog <= w_wdog;
    end
`endif

    always_comb begin
        w_state      = r_state;
        w_gap        = r_gap;
        w_ch_sel     = r_ch_sel;
        w_conv_start = 1'b0;
        w_cal_en     = r_cal_en;
        w_busy       = r_busy;
        w_layer_done = 1'b0;
        w_err        = r_err;
`ifdef POOL_WDOG_EN
        w_wdog       = r_wdog;
`endif
        if (abort) begin
            w_state  = S_IDLE;
            w_ch_sel = '0;
            w_cal_en = 1'b0;
            w_busy   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    w_state      = S_CONV;
                    w_ch_sel     = '0;
                    w_busy       = 1'b1;
                    w_conv_start = 1'b1;
                    w_err        = 1'b0;
                end
                S_CONV: if (conv_done) begin
                    w_state  = S_POOL;
                    w_cal_en = 1'b1;
`ifdef POOL_WDOG_EN
                    w_wdog   = WW'(1);
`endif
                end
                S_POOL: begin
                    if (pool_done) begin
                        w_state  = S_GAP;
                        w_cal_en = 1'b0;
                        w_gap    = GAP_LOAD;
                    end
`ifdef POOL_WDOG_EN
                    else if (r_wdog == WDOG_LIM) begin
                        w_state  = S_IDLE;
                        w_ch_sel = '0;
                        w_cal_en = 1'b0;
                        w_busy   = 1'b0;
                        w_err    = 1'b1;
                    end else begin
                        w_wdog = r_wdog + WW'(1);
                    end
`endif
                end
                S_GAP: begin
                    // Counter holds the number of GAP cycles still to run, this one included.
                    if (r_gap == GW'(1)) begin
                        if (r_ch_sel == LAST_CH) begin
                            w_state      = S_DONE;
                            w_layer_done = 1'b1;
                        end else begin
                            w_state      = S_CONV;
                            w_ch_sel     = r_ch_sel + CH_W'(1);
                            w_conv_start = 1'b1;
                        end
                    end else begin
                        w_gap = r_gap - GW'(1);
                    end
                end
                S_DONE: begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign conv_start = r_conv_start;
    assign cal_en     = r_cal_en;
    assign ch_sel     = r_ch_sel;
    assign busy       = r_busy;
    assign layer_done = r_layer_done;
    assign err        = r_err;

endmodule

// File: tb/tb_pool_channel_sched.sv
// tb/tb_pool_channel_sched.sv - scoreboard bench for pool_channel_sched
// Watchdog scenario runs only when POOL_WDOG_EN is defined.
module tb_pool_channel_sched;

    localparam int NUM_CH = 16;
    localparam int CH_W   = 4;
    localparam int GAP    = 2;
`ifdef POOL_WDOG_EN
    localparam int LONG_POOL = 15;
`else
    localparam int LONG_POOL = 110;
`endif
    localparam int K_CONV = 0;
    localparam int K_DONE = 1;

    typedef struct {
        int kind;
        int ch;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n, start, abort, conv_done, pool_done;
    logic            conv_start, cal_en, busy, layer_done, err;
    logic [CH_W-1:0] ch_sel;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_layer_done = 0;

    pool_channel_sched #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .GAP_CYC(GAP), .WDOG_CYC(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .conv_done(conv_done), .pool_done(pool_done),
        .conv_start(conv_start), .cal_en(cal_en), .ch_sel(ch_sel),
        .busy(busy), .layer_done(layer_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && (conv_start || layer_done)) begin
            n_checks++;
            if (layer_done) n_layer_done++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: conv_start=%0b layer_done=%0b ch_sel=%0d, no event expected",
                         conv_start, layer_done, ch_sel);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (conv_start != (e.kind == K_CONV) || layer_done != (e.kind == K_DONE) ||
                    (e.kind == K_CONV && int'(ch_sel) != e.ch)) begin
                    n_errors++;
                    $display("FAIL sb_event: got conv_start=%0b layer_done=%0b ch_sel=%0d, expected kind=%0d ch=%0d",
                             conv_start, layer_done, ch_sel, e.kind, e.ch);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic push(input int kind, input int ch);
        exp_t e;
        e.kind = kind;
        e.ch   = ch;
        q.push_back(e);
    endtask

    task automatic do_start();
        push(K_CONV, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_conv_start", conv_start, 1);
    endtask

    // Entered in the cycle conv_start is high for channel ch; returns in the
    // cycle the next conv_start (or layer_done, then busy low) is visible.
    task automatic run_ch(input int ch, input bit last, input int conv_lat,
                          input int pool_lat, input bit hold_pd, input bit poke);
        bit held;
        chk("ch_sel", ch_sel, ch);
        repeat (conv_lat) tick();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        chk("cal_en_rise", cal_en, 1);
        held = 1'b1;
        for (int i = 0; i < pool_lat; i++) begin
            if (poke && i == 0) begin
                start     = 1'b1;
                conv_done = 1'b1;
            end
            tick();
            start     = 1'b0;
            conv_done = 1'b0;
            if (!cal_en) held = 1'b0;
        end
        chk("cal_en_held", held, 1);
        pool_done = 1'b1;
        tick();
        if (!hold_pd) pool_done = 1'b0;
        chk("gap1_cal_en", cal_en, 0);
        chk("gap1_busy", busy, 1);
        tick();
        chk("gap2_cal_en", cal_en, 0);
        chk("gap2_conv_start", conv_start, 0);
        if (last) push(K_DONE, 0);
        else      push(K_CONV, ch + 1);
        tick();
        pool_done = 1'b0;
        if (last) begin
            chk("layer_done", layer_done, 1);
            chk("done_busy", busy, 1);
            tick();
            chk("busy_fall", busy, 0);
            chk("layer_done_pulse", layer_done, 0);
        end else begin
            chk("next_conv_start", conv_start, 1);
            chk("ch_advance", ch_sel, ch + 1);
        end
    endtask

    task automatic run_layer();
        do_start();
        for (int c = 0; c < NUM_CH; c++)
            run_ch(c, c == NUM_CH - 1, c % 3, 1 + c % 4, 1'b0, 1'b0);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_conv_start"}, conv_start, 0);
        chk({nm, "_cal_en"}, cal_en, 0);
        chk({nm, "_ch_sel"}, ch_sel, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_layer_done"}, layer_done, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; conv_done = 1'b0; pool_done = 1'b0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        chk("reset_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Completion inputs in IDLE are ignored.
        conv_done = 1'b1; pool_done = 1'b1;
        tick();
        conv_done = 1'b0; pool_done = 1'b0;
        tick();
        chk_idle_outputs("idle_ignore");

        // Layer 1: long first channel, stale pool_done across GAP, start poked mid-layer.
        do_start();
        run_ch(0, 1'b0, 3, LONG_POOL, 1'b0, 1'b0);
        run_ch(1, 1'b0, 3, 4, 1'b1, 1'b0);
        run_ch(2, 1'b0, 0, 3, 1'b0, 1'b1);
        for (int c = 3; c < NUM_CH; c++)
            run_ch(c, c == NUM_CH - 1, 1, 2, 1'b0, 1'b0);
        repeat (3) tick();
        chk("after_layer_busy", busy, 0);

        // Abort during POOL on channel 5, then a full layer from channel 0.
        do_start();
        for (int c = 0; c < 5; c++) run_ch(c, 1'b0, 1, 2, 1'b0, 1'b0);
        chk("abort_ch", ch_sel, 5);
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        tick(); tick();
        chk("abort_pre_cal_en", cal_en, 1);
        abort = 1'b1; pool_done = 1'b1;
        tick();
        abort = 1'b0; pool_done = 1'b0;
        chk_idle_outputs("abort");
        repeat (4) tick();
        run_layer();

        // Asynchronous reset during GAP of channel 2, then a full layer.
        do_start();
        run_ch(0, 1'b0, 0, 1, 1'b0, 1'b0);
        run_ch(1, 1'b0, 0, 1, 1'b0, 1'b0);
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        pool_done = 1'b1;
        tick();
        pool_done = 1'b0;
        chk("rst_pre_busy", busy, 1);
        chk("rst_pre_ch", ch_sel, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        run_layer();

`ifdef POOL_WDOG_EN
        do_start();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        repeat (19) tick();
        chk("wdog_cal_en_20", cal_en, 1);
        chk("wdog_err_early", err, 0);
        tick();
        chk("wdog_err", err, 1);
        chk("wdog_cal_en", cal_en, 0);
        chk("wdog_busy", busy, 0);
        chk("wdog_layer_done", layer_done, 0);
        tick();
        chk("wdog_err_sticky", err, 1);
        do_start();
        chk("wdog_err_clear", err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wdog_abort_busy", busy, 0);
`else
        chk("err_tied", err, 0);
`endif

        repeat (5) tick();
        chk("sb_queue_empty", q.size(), 0);
        chk("layer_done_count", n_layer_done, 3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
